control_sequencer: RTL and testbench

// - Timing/control unit of the basic computer: fetches, decodes and sequences each instruction, and generates alu_code for alu_unit.
// - Drives the register load/inc/clr strobes, bus select and memory strobes; alu_unit returns e_indata/ff_en directly to the E flip-flop.
// - Single clock; state advances on the rising edge of clk; all outputs are combinational decodes of the registered state and inputs.

---
 rtl/control_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Timing/control unit of the basic computer: fetch, decode and execute sequencing with strobe decode.
// Define INTR_EN to build in the interrupt flip-flops (ien, r) and the I/O instruction group.
module control_sequencer #(
  parameter int SC_W   = 4,
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [15:0]     ir_outdata,
  input  logic            ac_sign,
  input  logic            ac_zero,
  input  logic            dr_zero,
  input  logic            e_outdata,
  input  logic            fgi,
  input  logic            fgo,
  output logic [3:0]      alu_code,
  output logic [2:0]      bus_sel,
  output logic            ar_ld,
  output logic            ar_inc,
  output logic            pc_ld,
  output logic            pc_inc,
  output logic            pc_clr,
  output logic            dr_ld,
  output logic            dr_inc,
  output logic            ac_ld,
  output logic            ac_inc,
  output logic            ac_clr,
  output logic            ir_ld,
  output logic            tr_ld,
  output logic            e_clr,
  output logic            mem_rd,
  output logic            mem_wr,
`ifdef INTR_EN
  output logic            ar_clr,
`endif
  output logic [SC_W-1:0] sc_out,
  output logic            halted
);

  typedef enum logic [2:0] {
    BUS_NONE, BUS_AR, BUS_PC, BUS_DR, BUS_AC, BUS_IR, BUS_TR, BUS_MEM
  } bus_e;

  typedef enum logic [3:0] {
    ALU_NONE = 4'b0000, ALU_AND = 4'b0001, ALU_ADD = 4'b0010, ALU_LDA = 4'b0011,
    ALU_CMA  = 4'b1001, ALU_CME = 4'b1010, ALU_CIR = 4'b1011, ALU_CIL = 4'b1100
  } alu_e;

  typedef enum logic [2:0] {
    OP_AND, OP_ADD, OP_LDA, OP_STA, OP_BUN, OP_BSA, OP_ISZ, OP_IO
  } op_e;

  localparam logic [SC_W-1:0] T0 = SC_W'(0);
  localparam logic [SC_W-1:0] T1 = SC_W'(1);
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  localparam logic [SC_W-1:0] T3 = SC_W'(3);
  localparam logic [SC_W-1:0] T4 = SC_W'(4);
  localparam logic [SC_W-1:0] T5 = SC_W'(5);
  localparam logic [SC_W-1:0] T6 = SC_W'(6);

  if (SC_W < 3) begin : g_sc_w_check
    $error("SC_W must be at least 3 to reach T6");
  end

  logic [SC_W-1:0]   sc;
  logic              i_flag;
  logic              intr_cycle;
  op_e               opcode;
  logic              d7;
  logic [ADDR_W-1:0] op_bits;
  logic [11:0]       rr_sel;

  assign opcode  = op_e'(ir_outdata[14:12]);
  assign d7      = (opcode == OP_IO);
  assign op_bits = ir_outdata[ADDR_W-1:0];
  assign sc_out  = sc;

`ifdef INTR_EN
  logic ien;
  logic r;
  assign intr_cycle = r;
`else
  logic unused_flags;
  assign unused_flags = &{1'b0, fgi, fgo};
  assign intr_cycle   = 1'b0;
`endif

  // One-hot of the highest set bit; register-reference and I/O groups execute only that one.
  always_comb begin
    rr_sel = '0;
    for (int b = 11; b >= 0; b--) begin
      if (op_bits[b] && (rr_sel == '0)) rr_sel[b] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc     <= '0;
      halted <= 1'b0;
      i_flag <= 1'b0;
`ifdef INTR_EN
      ien    <= 1'b0;
      r      <= 1'b0;
`endif
    end else if (!halted) begin
      if (intr_cycle && (sc <= T2)) begin
        if (sc == T2) begin
          sc <= '0;
`ifdef INTR_EN
          ien <= 1'b0;
          r   <= 1'b0;
`endif
        end else begin
          sc <= sc + 1'b1;
        end
      end else begin
        case (sc)
          T0, T1: sc <= sc + 1'b1;
          T2: begin
            i_flag <= ir_outdata[15];
            sc     <= T3;
`ifdef INTR_EN
            if (ien && (fgi || fgo)) r <= 1'b1;
`endif
          end
          T3: begin
            if (d7) begin
              sc <= '0;
              if (!i_flag && rr_sel[0]) halted <= 1'b1;
`ifdef INTR_EN
              if (i_flag && rr_sel[7]) ien <= 1'b1;
              if (i_flag && rr_sel[6]) ien <= 1'b0;
`endif
            end else begin
              sc <= T4;
            end
          end
          T4: sc <= ((opcode == OP_STA) || (opcode == OP_BUN)) ? '0 : T5;
          T5: sc <= (opcode == OP_ISZ) ? T6 : '0;
          default: sc <= '0;
        endcase
      end
    end
  end

  // NOTE: every output is defaulted first so the decode infers no latches; gating with reset_n
  // makes a mid-instruction reset drop all strobes immediately rather than at the next edge.
  always_comb begin
    alu_code = ALU_NONE;
    bus_sel  = BUS_NONE;
    ar_ld = 1'b0; ar_inc = 1'b0;
    pc_ld = 1'b0; pc_inc = 1'b0; pc_clr = 1'b0;
    dr_ld = 1'b0; dr_inc = 1'b0;
    ac_ld = 1'b0; ac_inc = 1'b0; ac_clr = 1'b0;
    ir_ld = 1'b0; tr_ld  = 1'b0; e_clr  = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0;
`ifdef INTR_EN
    ar_clr = 1'b0;
`endif
    if (reset_n && !halted) begin
      if (intr_cycle && (sc <= T2)) begin
`ifdef INTR_EN
        case (sc)
          T0: begin ar_clr = 1'b1; tr_ld = 1'b1; bus_sel = BUS_PC; end
          T1: begin mem_wr = 1'b1; bus_sel = BUS_TR; pc_clr = 1'b1; end
          default: pc_inc = 1'b1;
        endcase
`endif
      end else begin
        case (sc)
          T0: begin bus_sel = BUS_PC; ar_ld = 1'b1; end
          T1: begin mem_rd = 1'b1; bus_sel = BUS_MEM; ir_ld = 1'b1; pc_inc = 1'b1; end
          T2: begin bus_sel = BUS_IR; ar_ld = 1'b1; end
          T3: begin
            if (d7 && !i_flag) begin
              if (rr_sel[11]) ac_clr = 1'b1;
              if (rr_sel[10]) e_clr = 1'b1;
              if (rr_sel[9])  alu_code = ALU_CMA;
              if (rr_sel[8])  alu_code = ALU_CME;
              if (rr_sel[7])  alu_code = ALU_CIR;
              if (rr_sel[6])  alu_code = ALU_CIL;
              if (rr_sel[5])  ac_inc = 1'b1;
              if (rr_sel[4] && !ac_sign)   pc_inc = 1'b1;
              if (rr_sel[3] && ac_sign)    pc_inc = 1'b1;
              if (rr_sel[2] && ac_zero)    pc_inc = 1'b1;
              if (rr_sel[1] && !e_outdata) pc_inc = 1'b1;
            end else if (d7) begin
`ifdef INTR_EN
              // INPR reaches AC outside this block; OUT places AC on the bus for OUTR.
              if (rr_sel[11]) ac_ld = 1'b1;
              if (rr_sel[10]) bus_sel = BUS_AC;
              if (rr_sel[9] && fgi) pc_inc = 1'b1;
              if (rr_sel[8] && fgo) pc_inc = 1'b1;
`endif
            end else if (i_flag) begin
              mem_rd = 1'b1; bus_sel = BUS_MEM; ar_ld = 1'b1;
            end
          end
          T4: begin
            case (opcode)
              OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin mem_rd = 1'b1; bus_sel = BUS_MEM; dr_ld = 1'b1; end
              OP_STA: begin mem_wr = 1'b1; bus_sel = BUS_AC; end
              OP_BUN: begin bus_sel = BUS_AR; pc_ld = 1'b1; end
              OP_BSA: begin mem_wr = 1'b1; bus_sel = BUS_PC; ar_inc = 1'b1; end
              default: ;
            endcase
          end
          T5: begin
            case (opcode)
              OP_AND: begin alu_code = ALU_AND; ac_ld = 1'b1; end
              OP_ADD: begin alu_code = ALU_ADD; ac_ld = 1'b1; end
              OP_LDA: begin alu_code = ALU_LDA; ac_ld = 1'b1; end
              OP_BSA: begin bus_sel = BUS_AR; pc_ld = 1'b1; end
              OP_ISZ: dr_inc = 1'b1;
              default: ;
            endcase
          end
          T6: begin
            if (opcode == OP_ISZ) begin
              mem_wr = 1'b1; bus_sel = BUS_DR; pc_inc = dr_zero;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle stimulus and expected outputs are queued, then replayed.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam int SC_W = 4;

  localparam logic [15:0] AR_LD  = 16'h0001, AR_INC = 16'h0002, PC_LD  = 16'h0004, PC_INC = 16'h0008;
  localparam logic [15:0] PC_CLR = 16'h0010, DR_LD  = 16'h0020, DR_INC = 16'h0040, AC_LD  = 16'h0080;
  localparam logic [15:0] AC_INC = 16'h0100, AC_CLR = 16'h0200, IR_LD  = 16'h0400, TR_LD  = 16'h0800;
  localparam logic [15:0] E_CLR  = 16'h1000, MEM_RD = 16'h2000, MEM_WR = 16'h4000, AR_CLR = 16'h8000;
  localparam logic [2:0]  B_NONE = 3'd0, B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3;
  localparam logic [2:0]  B_AC = 3'd4, B_IR = 3'd5, B_TR = 3'd6, B_MEM = 3'd7;

  typedef struct packed {
    logic [3:0]      alu;
    logic [2:0]      bus;
    logic [15:0]     stb;
    logic [SC_W-1:0] sc;
    logic            halted;
  } obs_t;

  typedef struct packed {
    logic [63:0] tag;
    logic [15:0] ir;
    logic        ac_sign, ac_zero, dr_zero, e, fgi, fgo;
    obs_t        exp;
  } step_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] ir_outdata = 16'h0000;
  logic ac_sign = 1'b0, ac_zero = 1'b0, dr_zero = 1'b0, e_outdata = 1'b0, fgi = 1'b0, fgo = 1'b0;
  logic [3:0] alu_code;
  logic [2:0] bus_sel;
  logic ar_ld, ar_inc, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc, ac_ld, ac_inc, ac_clr;
  logic ir_ld, tr_ld, e_clr, mem_rd, mem_wr, halted, ar_clr_w;
  logic [SC_W-1:0] sc_out;
  obs_t obs;

  step_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] env_ir = 16'h0000;
  logic env_ac_sign = 1'b0, env_ac_zero = 1'b0, env_dr_zero = 1'b0, env_e = 1'b0, env_fgi = 1'b0, env_fgo = 1'b0;

`ifdef INTR_EN
  logic ar_clr;
  assign ar_clr_w = ar_clr;
`else
  assign ar_clr_w = 1'b0;
`endif

  always #5 clk = ~clk;

  control_sequencer #(.SC_W(SC_W), .ADDR_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .ir_outdata(ir_outdata),
    .ac_sign(ac_sign), .ac_zero(ac_zero), .dr_zero(dr_zero), .e_outdata(e_outdata),
    .fgi(fgi), .fgo(fgo), .alu_code(alu_code), .bus_sel(bus_sel),
    .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_clr(pc_clr),
    .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld), .ac_inc(ac_inc), .ac_clr(ac_clr),
    .ir_ld(ir_ld), .tr_ld(tr_ld), .e_clr(e_clr), .mem_rd(mem_rd), .mem_wr(mem_wr),
`ifdef INTR_EN
    .ar_clr(ar_clr),
`endif
    .sc_out(sc_out), .halted(halted)
  );

  assign obs = {alu_code, bus_sel,
                {ar_clr_w, mem_wr, mem_rd, e_clr, tr_ld, ir_ld, ac_clr, ac_inc,
                 ac_ld, dr_inc, dr_ld, pc_clr, pc_inc, pc_ld, ar_inc, ar_ld},
                sc_out, halted};

  task automatic push(input logic [63:0] tag, input int sc, input logic [2:0] bus,
                      input logic [3:0] alu, input logic [15:0] stb, input logic hlt);
    step_t s;
    s.tag = tag; s.ir = env_ir;
    s.ac_sign = env_ac_sign; s.ac_zero = env_ac_zero; s.dr_zero = env_dr_zero;
    s.e = env_e; s.fgi = env_fgi; s.fgo = env_fgo;
    s.exp.alu = alu; s.exp.bus = bus; s.exp.stb = stb;
    s.exp.sc = SC_W'(sc); s.exp.halted = hlt;
    sb.push_back(s);
  endtask

  // Register-reference reference model: only the highest set bit of IR[11:0] acts.
  task automatic rr_model(input logic [15:0] ir, output logic [3:0] alu, output logic [15:0] stb);
    alu = 4'h0; stb = '0;
    for (int b = 11; b >= 0; b--) begin
      if (ir[b]) begin
        case (b)
          11: stb = AC_CLR;
          10: stb = E_CLR;
          9:  alu = 4'b1001;
          8:  alu = 4'b1010;
          7:  alu = 4'b1011;
          6:  alu = 4'b1100;
          5:  stb = AC_INC;
          4:  stb = env_ac_sign ? 16'h0 : PC_INC;
          3:  stb = env_ac_sign ? PC_INC : 16'h0;
          2:  stb = env_ac_zero ? PC_INC : 16'h0;
          1:  stb = env_e ? 16'h0 : PC_INC;
          default: stb = '0;
        endcase
        break;
      end
    end
  endtask

  task automatic io_model(input logic [15:0] ir, output logic [2:0] bus, output logic [15:0] stb);
    bus = B_NONE; stb = '0;
`ifdef INTR_EN
    if (ir[11])     stb = AC_LD;
    else if (ir[10]) bus = B_AC;
    else if (ir[9])  stb = env_fgi ? PC_INC : 16'h0;
    else if (ir[8])  stb = env_fgo ? PC_INC : 16'h0;
`endif
  endtask

  task automatic push_instr(input logic [15:0] ir);
    logic [2:0]  op;
    logic [3:0]  alu;
    logic [2:0]  bus;
    logic [15:0] stb;
    op = ir[14:12];
    env_ir = ir;
    push("T0", 0, B_PC, 4'h0, AR_LD, 1'b0);
    push("T1", 1, B_MEM, 4'h0, MEM_RD | IR_LD | PC_INC, 1'b0);
    push("T2", 2, B_IR, 4'h0, AR_LD, 1'b0);
    if (op == 3'b111) begin
      if (!ir[15]) begin
        rr_model(ir, alu, stb);
        push("T3rr", 3, B_NONE, alu, stb, 1'b0);
      end else begin
        io_model(ir, bus, stb);
        push("T3io", 3, bus, 4'h0, stb, 1'b0);
      end
    end else begin
      if (ir[15]) push("T3ind", 3, B_MEM, 4'h0, MEM_RD | AR_LD, 1'b0);
      else        push("T3idle", 3, B_NONE, 4'h0, 16'h0, 1'b0);
      case (op)
        3'd0: begin push("T4and", 4, B_MEM, 4'h0, MEM_RD | DR_LD, 1'b0); push("T5and", 5, B_NONE, 4'b0001, AC_LD, 1'b0); end
        3'd1: begin push("T4add", 4, B_MEM, 4'h0, MEM_RD | DR_LD, 1'b0); push("T5add", 5, B_NONE, 4'b0010, AC_LD, 1'b0); end
        3'd2: begin push("T4lda", 4, B_MEM, 4'h0, MEM_RD | DR_LD, 1'b0); push("T5lda", 5, B_NONE, 4'b0011, AC_LD, 1'b0); end
        3'd3: push("T4sta", 4, B_AC, 4'h0, MEM_WR, 1'b0);
        3'd4: push("T4bun", 4, B_AR, 4'h0, PC_LD, 1'b0);
        3'd5: begin push("T4bsa", 4, B_PC, 4'h0, MEM_WR | AR_INC, 1'b0); push("T5bsa", 5, B_AR, 4'h0, PC_LD, 1'b0); end
        default: begin
          push("T4isz", 4, B_MEM, 4'h0, MEM_RD | DR_LD, 1'b0);
          push("T5isz", 5, B_NONE, 4'h0, DR_INC, 1'b0);
          push("T6isz", 6, B_DR, 4'h0, MEM_WR | (env_dr_zero ? PC_INC : 16'h0), 1'b0);
        end
      endcase
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ir_outdata = (k == 0) ? 16'h7800 : 16'hE020;
      #1;
      n_cmp++;
      if (obs !== obs_t'(0)) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %h want %h", k, obs, obs_t'(0));
      end
    end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_cla_add();
    step_t s;
    push_instr(16'h7800);
    push_instr(16'h1010);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      ir_outdata = s.ir; ac_sign = s.ac_sign; ac_zero = s.ac_zero; dr_zero = s.dr_zero;
      e_outdata = s.e; fgi = s.fgi; fgo = s.fgo;
      #1;
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL cla_add %0s ir=%h: got %h want %h", s.tag, s.ir, obs, s.exp);
      end
    end
  endtask

  task automatic test_isz_indirect();
    step_t s;
    env_dr_zero = 1'b1; push_instr(16'hE020);
    env_dr_zero = 1'b0; push_instr(16'h6020);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      ir_outdata = s.ir; ac_sign = s.ac_sign; ac_zero = s.ac_zero; dr_zero = s.dr_zero;
      e_outdata = s.e; fgi = s.fgi; fgo = s.fgo;
      #1;
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL isz %0s ir=%h: got %h want %h", s.tag, s.ir, obs, s.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    logic [18:0] prog [24];
    // {ac_sign, ac_zero, e, ir}
    prog = '{{3'b000, 16'h7400}, {3'b000, 16'h7200}, {3'b000, 16'h7100}, {3'b000, 16'h7080},
             {3'b000, 16'h7040}, {3'b000, 16'h7020}, {3'b000, 16'h7010}, {3'b100, 16'h7010},
             {3'b100, 16'h7008}, {3'b000, 16'h7008}, {3'b010, 16'h7004}, {3'b000, 16'h7004},
             {3'b000, 16'h7002}, {3'b001, 16'h7002}, {3'b000, 16'h7A00}, {3'b000, 16'h7000},
             {3'b000, 16'h7003}, {3'b000, 16'hF800}, {3'b000, 16'h0123}, {3'b000, 16'h2456},
             {3'b000, 16'h3789}, {3'b000, 16'h4ABC}, {3'b000, 16'h5DEF}, {3'b000, 16'hD111}};
    foreach (prog[i]) begin
      env_ac_sign = prog[i][18]; env_ac_zero = prog[i][17]; env_e = prog[i][16];
      push_instr(prog[i][15:0]);
    end
    env_ac_sign = 1'b0; env_ac_zero = 1'b0; env_e = 1'b0;
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      ir_outdata = s.ir; ac_sign = s.ac_sign; ac_zero = s.ac_zero; dr_zero = s.dr_zero;
      e_outdata = s.e; fgi = s.fgi; fgo = s.fgo;
      #1;
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL b2b %0s ir=%h: got %h want %h", s.tag, s.ir, obs, s.exp);
      end
    end
  endtask

  task automatic test_halt();
    step_t s;
    push_instr(16'h7001);
    for (int k = 0; k < 20; k++) push("halt", 0, B_NONE, 4'h0, 16'h0, 1'b1);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      ir_outdata = s.ir; ac_sign = s.ac_sign; ac_zero = s.ac_zero; dr_zero = s.dr_zero;
      e_outdata = s.e; fgi = s.fgi; fgo = s.fgo;
      #1;
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL halt %0s ir=%h: got %h want %h", s.tag, s.ir, obs, s.exp);
      end
    end
    @(negedge clk); reset_n = 1'b0; #1;
    n_cmp++;
    if (obs !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL halt_reset: got %h want %h", obs, obs_t'(0));
    end
    @(posedge clk); #1 reset_n = 1'b1;
    push_instr(16'h7800);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      ir_outdata = s.ir; ac_sign = s.ac_sign; ac_zero = s.ac_zero; dr_zero = s.dr_zero;
      e_outdata = s.e; fgi = s.fgi; fgo = s.fgo;
      #1;
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL resume %0s ir=%h: got %h want %h", s.tag, s.ir, obs, s.exp);
      end
    end
  endtask

  task automatic test_reset_mid_bsa();
    step_t s;
    push_instr(16'h5123);
    void'(sb.pop_back());
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      ir_outdata = s.ir; ac_sign = s.ac_sign; ac_zero = s.ac_zero; dr_zero = s.dr_zero;
      e_outdata = s.e; fgi = s.fgi; fgo = s.fgo;
      #1;
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL bsa %0s ir=%h: got %h want %h", s.tag, s.ir, obs, s.exp);
      end
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL bsa_abort: got %h want %h", obs, obs_t'(0));
    end
    @(posedge clk); #1 reset_n = 1'b1;
    push_instr(16'h7800);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      ir_outdata = s.ir; ac_sign = s.ac_sign; ac_zero = s.ac_zero; dr_zero = s.dr_zero;
      e_outdata = s.e; fgi = s.fgi; fgo = s.fgo;
      #1;
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL after_abort %0s ir=%h: got %h want %h", s.tag, s.ir, obs, s.exp);
      end
    end
  endtask

`ifdef INTR_EN
  task automatic test_interrupt();
    step_t s;
    push_instr(16'hF080);
    env_fgi = 1'b1;
    push_instr(16'h7800);
    push("I0", 0, B_PC, 4'h0, AR_CLR | TR_LD, 1'b0);
    push("I1", 1, B_TR, 4'h0, MEM_WR | PC_CLR, 1'b0);
    push("I2", 2, B_NONE, 4'h0, PC_INC, 1'b0);
    push_instr(16'h7800);
    push_instr(16'h7800);
    env_fgi = 1'b0;
    while (sb.size() != 0) begin
      s = sb.pop_front();
      @(negedge clk);
      ir_outdata = s.ir; ac_sign = s.ac_sign; ac_zero = s.ac_zero; dr_zero = s.dr_zero;
      e_outdata = s.e; fgi = s.fgi; fgo = s.fgo;
      #1;
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL intr %0s ir=%h: got %h want %h", s.tag, s.ir, obs, s.exp);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cla_add();
    test_isz_indirect();
    test_back_to_back();
    test_halt();
    test_reset_mid_bsa();
`ifdef INTR_EN
    test_interrupt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
